// File: rtl/dac_pkg.sv
// Shared constants and frame packing for the MCP4821 DAC data path.
package dac_pkg;

    localparam int DAC_W      = 12;
    localparam int FRAME_W    = 16;
    localparam int MID_CODE   = 2048;
    localparam int FRAME_AB   = 15;
    localparam int FRAME_GA   = 13;
    localparam int FRAME_SHDN = 12;

    typedef logic [DAC_W-1:0]   sample_t;
    typedef logic [FRAME_W-1:0] frame_t;

    function automatic frame_t pack_frame(
        input logic    ga,
        input logic    shdn,
        input sample_t smp
    );
        frame_t f;
        f              = '0;
        f[FRAME_AB]    = 1'b0;
        f[FRAME_GA]    = ga;
        f[FRAME_SHDN]  = shdn;
        f[DAC_W-1:0]   = smp;
        return f;
    endfunction

endpackage

// File: rtl/sine_qlut.sv
// Registered quarter-wave sine ROM, 11-bit magnitude, half-step centred.
module sine_qlut #(
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [10:0]       dout
);

    localparam int N = 2 ** LUT_AW;

    function automatic logic [N*11-1:0] rom_init();
        logic [N*11-1:0] r;
        real             ph;
        int              v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            ph = 2.0 * 3.141592653589793 * (real'(i) + 0.5) / real'(4 * N);
            v  = $rtoi(2047.0 * $sin(ph) + 0.5);
            r[i*11 +: 11] = 11'(v);
        end
        return r;
    endfunction

    localparam logic [N*11-1:0] ROM = rom_init();

    always_ff @(posedge clk) begin
        dout <= ROM[int'(addr)*11 +: 11];
    end

endmodule

// File: rtl/dds_sine_frame_gen.sv
// DDS sine sample source packing MCP4821 frames behind a valid/ready holding register.
// Define AMPL_SCALE_EN to add the ampl input and an amplitude-scaling stage.
module dds_sine_frame_gen
    import dac_pkg::*;
#(
    parameter int TICK_DIV = 200,
    parameter int ACC_W    = 32,
    parameter int LUT_AW   = 8
) (
`ifdef AMPL_SCALE_EN
    input  logic [8:0]         ampl,
`endif
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [ACC_W-1:0]   ftw,
    input  logic               gain_n,
    input  logic               shdn_n,
    input  logic               ovr_clr,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               overrun
);

    localparam int          IDX_W   = LUT_AW + 2;
    localparam logic [15:0] DIV_MAX = 16'(TICK_DIV - 1);

    logic [15:0]       div_q;
    logic              tick_q;
    logic [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]  idx_q;
    logic              v0_q;
    logic              hi_q;
    logic              v1_q;
    logic [LUT_AW-1:0] lut_addr;
    logic [10:0]       lut_q;
    sample_t           unfold_c;
    sample_t           new_s;
    logic              new_v;
    frame_t            frame_q, frame_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= en && (div_q == DIV_MAX);
            if (!en || div_q == DIV_MAX) div_q <= '0;
            else                         div_q <= div_q + 16'd1;
        end
    end

    // Phase is read before the update so the first tick plays index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
            v0_q  <= 1'b0;
            hi_q  <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            v0_q <= tick_q;
            v1_q <= v0_q;
            hi_q <= idx_q[IDX_W-1];
            if (tick_q) begin
                idx_q <= acc_q[ACC_W-1 -: IDX_W];
                acc_q <= acc_q + ftw;
            end
        end
    end

    assign lut_addr = idx_q[LUT_AW] ? ~idx_q[LUT_AW-1:0] : idx_q[LUT_AW-1:0];

    sine_qlut #(.LUT_AW(LUT_AW)) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .dout (lut_q)
    );

    assign unfold_c = hi_q ? sample_t'(MID_CODE - 1) - {1'b0, lut_q}
                           : sample_t'(MID_CODE) + {1'b0, lut_q};

`ifdef AMPL_SCALE_EN
    sample_t            smp2_q;
    logic               v2_q;
    logic [8:0]         amp_c;
    logic signed [12:0] s_c;
    logic signed [22:0] prod_c;
    logic               unused_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            smp2_q <= unfold_c;
            v2_q   <= v1_q;
        end
    end

    assign amp_c       = (ampl > 9'd256) ? 9'd256 : ampl;
    assign s_c         = $signed({1'b0, smp2_q}) - 13'sd2048;
    assign prod_c      = s_c * $signed({1'b0, amp_c});
    assign unused_prod = ^{prod_c[22:20], prod_c[7:0]};
    // Result lies in -2048..2047, so the low 12 bits re-biased are exact.
    assign new_s       = prod_c[19:8] + sample_t'(MID_CODE);
    assign new_v       = v2_q;
`else
    assign new_s = unfold_c;
    assign new_v = v1_q;
`endif

    assign xfer = valid_q & frame_ready;

    always_comb begin
        frame_d = frame_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ovr_clr) ovr_d = 1'b0;
        if (new_v) begin
            if (!valid_q || xfer) begin
                frame_d = pack_frame(gain_n, shdn_n, new_s);
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            frame_q <= frame_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_dds_sine_frame_gen.sv
// Scoreboard bench for dds_sine_frame_gen: phase/sine model feeds an expected-frame queue.
module tb_dds_sine_frame_gen;

    localparam int  TD = 200;
`ifdef AMPL_SCALE_EN
    localparam int  LAT = 4;
`else
    localparam int  LAT = 3;
`endif
    localparam real PI = 3.141592653589793;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] ftw;
    logic        gain_n;
    logic        shdn_n;
    logic        ovr_clr;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        overrun;
`ifdef AMPL_SCALE_EN
    logic [8:0]  ampl;
`endif

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] q[$];
    logic [15:0] last_exp  = '0;
    logic [15:0] last_xfer = '0;
    logic [31:0] phase;
    int          rdy_mode = 1;

    always #5 clk = ~clk;

    dds_sine_frame_gen dut (
`ifdef AMPL_SCALE_EN
        .ampl        (ampl),
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ftw         (ftw),
        .gain_n      (gain_n),
        .shdn_n      (shdn_n),
        .ovr_clr     (ovr_clr),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Full-wave sine at the half-step-centred phase, then optional amplitude scaling.
    function automatic logic [11:0] ref_sample(input logic [9:0] idx, input int am);
        real a;
        int  v, smp, t, aa;
        a   = $sin(2.0 * PI * (real'(idx) + 0.5) / 1024.0);
        v   = $rtoi(2047.0 * (a < 0.0 ? -a : a) + 0.5);
        smp = (a >= 0.0) ? 2048 + v : 2047 - v;
        aa  = (am > 256) ? 256 : am;
        t   = (smp - 2048) * aa;
        smp = 2048 + ((t >= 0) ? t / 256 : -((-t + 255) / 256));
        return 12'(smp);
    endfunction

    task automatic issue(input logic [31:0] f, input logic g, input logic s,
                         input int am, input bit push);
        logic [9:0]  idx;
        logic [15:0] e;
        ftw    = f;
        gain_n = g;
        shdn_n = s;
`ifdef AMPL_SCALE_EN
        ampl   = 9'(am);
`endif
        idx   = phase[31:22];
        phase = phase + f;
        if (push) begin
            e = {2'b00, g, s, ref_sample(idx, am)};
            q.push_back(e);
            last_exp = e;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        frame_ready = (rdy_mode == 1) || (rdy_mode == 0 && $urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL xfer: got unexpected frame 0x%0h, expected none", frame);
            end else begin
                chk("xfer", 32'(frame), 32'(q.pop_front()));
            end
            last_xfer = frame;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] exp_c [3];
        logic [15:0] held;
        int          n;
        int          am;
        exp_c = '{12'd4095, 12'd2041, 12'd0};
        rst_n = 1'b0; en = 1'b0; ftw = '0; gain_n = 1'b0; shdn_n = 1'b0;
        ovr_clr = 1'b0; phase = '0;
`ifdef AMPL_SCALE_EN
        ampl = 9'd256;
`endif
        step(3);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step(1);

        en = 1'b1;
        issue(32'h0040_0000, 1'b1, 1'b1, 256, 1'b1);
        n = 0;
        while (!frame_valid && n < 400) begin step(1); n++; end
        chk("en_to_valid", 32'(n), 32'(TD + LAT));
        chk("first_frame", 32'(frame), 32'h3806);
        step(5 - LAT);

        issue(32'h3FC0_0000, 1'b1, 1'b1, 256, 1'b1);
        n = 0;
        while (!frame_valid && n < 400) begin step(1); n++; end
        chk("valid_period", 32'(n + 5 - LAT), 32'(TD));
        step(5 - LAT);

        for (int k = 0; k < 3; k++) begin
            issue(32'h4000_0000, 1'b1, 1'b1, 256, 1'b1);
            step(TD);
            chk("quarter_points", 32'(last_xfer[11:0]), 32'(exp_c[k]));
        end

        rdy_mode = 0;
        for (int k = 0; k < 60; k++) begin
`ifdef AMPL_SCALE_EN
            am = int'($urandom_range(0, 511));
`else
            am = 256;
`endif
            issue($urandom, 1'($urandom), 1'($urandom), am, 1'b1);
            step(TD);
        end
        rdy_mode = 1;
        issue($urandom, 1'b1, 1'b1, 256, 1'b1);
        step(TD);
        chk("no_overrun_random", 32'(overrun), 0);

        rdy_mode = 2;
        issue($urandom, 1'b1, 1'b1, 256, 1'b1);
        step(TD);
        chk("held_valid", 32'(frame_valid), 1);
        chk("held_frame", 32'(frame), 32'(last_exp));
        chk("overrun_pre", 32'(overrun), 0);
        held = frame;
        issue($urandom, 1'b0, 1'b0, 256, 1'b0);
        step(TD);
        chk("hold_after_drop", 32'(frame), 32'(held));
        chk("overrun_set", 32'(overrun), 1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        issue($urandom, 1'b0, 1'b1, 256, 1'b0);
        step(193 + LAT);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        chk("set_wins", 32'(overrun), 1);
        chk("hold_after_drop2", 32'(frame), 32'(held));
        step(5 - LAT);
        rdy_mode = 1;
        issue($urandom, 1'b1, 1'b1, 256, 1'b1);
        step(TD);
        chk("ovr_sticky", 32'(overrun), 1);

        rdy_mode = 2;
        issue($urandom, 1'b1, 1'b0, 256, 1'b1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        chk("ovr_clr2", 32'(overrun), 0);
        step(194 + LAT);
        chk("pend_valid", 32'(frame_valid), 1);
        issue($urandom, 1'b1, 1'b1, 256, 1'b0);
        step(201 - LAT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_frame", 32'(frame), 0);
        chk("async_valid", 32'(frame_valid), 0);
        chk("async_overrun", 32'(overrun), 0);
        q.delete();
        phase = '0;
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        rdy_mode = 1;
        step(1);
        en = 1'b1;
        issue(32'h0040_0000, 1'b1, 1'b1, 256, 1'b1);
        n = 0;
        while (!frame_valid && n < 400) begin step(1); n++; end
        chk("rst_en_to_valid", 32'(n), 32'(TD + LAT));
        chk("rst_first_frame", 32'(frame), 32'h3806);
        step(5 - LAT);

        issue($urandom, 1'b0, 1'b1, 256, 1'b1);
        step(196);
        en = 1'b0;
        step(20);
        chk("inflight_emitted", 32'(q.size()), 0);
        step(2 * TD);
        chk("idle_valid", 32'(frame_valid), 0);
        chk("idle_queue", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dds_sine_frame_gen.md
Name: dds_sine_frame_gen

Overview:
Upstream sample source for the SPI DAC transmitter. It uses a phase accumulator (DDS) with a quarter-wave sine LUT to produce 12-bit offset-binary sine samples at a programmable sample rate. Each sample is packed into a 16-bit MCP4821 command frame. Frames are offered to the SPI master over a valid/ready handshake, with a one-entry holding register and overrun detection.

Parameters:
TICK_DIV, 200, sample period in clk cycles (tick when divider = TICK_DIV-1); legal range 34..65535
ACC_W, 32, phase accumulator / tuning word width
LUT_AW, 8, quarter-wave LUT address width; full-wave index = LUT_AW+2 bits

Ports:
clk  in  1  system clock (PLL output)
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes divider (held at 0) and accumulator
ftw  in  ACC_W  frequency tuning word; f_out = ftw*f_clk/(TICK_DIV*2^ACC_W)
gain_n  in  1  DAC GA bit, copied into frame
shdn_n  in  1  DAC SHDN bit, copied into frame
ovr_clr  in  1  clears overrun flag
frame  out  16  {1'b0, 1'b0, gain_n, shdn_n, sample[11:0]}
frame_valid  out  1  frame holds an unaccepted sample
frame_ready  in  1  SPI master accepts (drive with ~busy)
overrun  out  1  sticky: sample produced while previous frame still pending
ampl  in  9  amplitude, 256 = unity (present only with AMPL_SCALE_EN)

Behaviour:
- Reset values: frame=16'h0000, frame_valid=0, overrun=0; accumulator, divider and pipeline registers = 0.
- Divider: counts 0..TICK_DIV-1 while en=1. Registered tick pulse is 1 cycle wide on wrap.
- Stage 0 (tick cycle):
  - idx = acc[ACC_W-1 -: LUT_AW+2], taken from the pre-update value.
  - acc <= acc + ftw, modulo 2^ACC_W; wrap is silent.
  - ftw is sampled only on tick.
- Stage 1 (LUT address fold):
  - quadrant = idx[LUT_AW+1:LUT_AW], offset = idx[LUT_AW-1:0].
  - addr = quadrant[0] ? ~offset : offset.
  - Registered LUT read: q[i] = round(2047*sin(2*pi*(i+0.5)/2^(LUT_AW+2))), 11 bits, range 0..2047.
- Stage 2 (unfold): sample = quadrant[1] ? 2047-q : 2048+q, range 0..4095, no overflow possible.
- Frame register loads on the stage-2 result. gain_n and shdn_n are sampled in the same cycle. Bit 14 is driven 0.
- Latency: frame_valid rises 3 cycles after the tick pulse.
- Handshake: a frame is transferred on any cycle with frame_valid & frame_ready, after which frame_valid drops. frame stays stable while valid & ~ready.
- New stage-2 result while frame_valid=1 and not transferring in that same cycle:
  - the new sample is dropped and overrun <= 1;
  - the pending frame is kept;
  - the accumulator still advances, preserving phase continuity.
- Transfer and new result in the same cycle: the new frame loads, valid stays 1, no overrun.
- ovr_clr and a new overrun event in the same cycle: overrun stays 1 (set wins).
- en deasserted mid-pipeline: in-flight stages complete and emit. No new ticks are generated; frame_valid persists until accepted.
- rst_n asserted: everything returns to reset values immediately (asynchronous), including a pending frame.

Optional Feature:
Macro AMPL_SCALE_EN.
- Defined:
  - ampl port exists; values above 256 are clamped to 256.
  - Stage 3 computes s = sample-2048 (13-bit signed), then out = 2048 + ((s*ampl) >>> 8), truncated toward -inf.
  - Latency becomes 4 cycles. ampl is sampled at stage 3.
- Undefined: no ampl port, no multiplier, latency 3, sample passes through unchanged.

Decomposition:
- Shared package dac_pkg:
  - frame bit positions (FRAME_GA=13, FRAME_SHDN=12, FRAME_AB=15);
  - DAC_W=12, FRAME_W=16, MID_CODE=2048.
- Sub-module sine_qlut: registered 2^LUT_AW x 11 ROM, generated by initial/$sin or loaded from a .mem file, with ports clk, addr, dout.

Test Plan:
1. ftw=2^22 (1 index/tick), TICK_DIV=200, frame_ready=1 → first frame 0x3806 (gain_n=1, shdn_n=1, sample 2054) 3 cycles after the first tick; samples at idx 256/512/768 = 4095/2041/0.
2. Latency and period: measure tick-to-valid = 3 cycles and valid-to-valid = 200 cycles. With AMPL_SCALE_EN: 4 cycles.
3. frame_ready held 0 across two ticks → first frame held stable, overrun=1 after the second result. Release ready → the first frame is transferred, and the next frame after that corresponds to idx+2 (phase continuity).
4. ovr_clr pulse → overrun=0. Repeat with ovr_clr coincident with a new overrun → overrun stays 1.
5. rst_n pulsed while frame_valid=1 and the pipeline is loaded → all outputs 0 asynchronously. After release, first frame sample = 2054 again.
6. AMPL_SCALE_EN, ampl=128, idx 256 → sample 2048+(2047*128>>>8)=3071; ampl=0 → 2048 constant; ampl=300 → clamped, sample at idx 256 = 4095.
